// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipeline stage buffers.
//   MEMWB_DATA_W / REG_ADDR_W : default datapath and register-index widths
//   memwb_payload_t           : packed MEM/WB beat, reused by the other
//                               stage buffers that move the same fields
//   memwb_payload_w()         : flat width of a MEM/WB beat for arbitrary
//                               data/address widths (parametrised stages
//                               cannot use the fixed-width struct directly)
// ---------------------------------------------------------------------------
package pipe_pkg;

    localparam int MEMWB_DATA_W = 32;
    localparam int REG_ADDR_W   = 5;

    typedef struct packed {
        logic [MEMWB_DATA_W-1:0] mem_data;
        logic [MEMWB_DATA_W-1:0] alu_result;
        logic [REG_ADDR_W-1:0]   rd;
        logic                    reg_write;
        logic                    mem_to_reg;
    } memwb_payload_t;

    localparam int MEMWB_PAYLOAD_W = $bits(memwb_payload_t);

    // Field order of the flat vector matches memwb_payload_t:
    // {mem_data, alu_result, rd, reg_write, mem_to_reg}
    function automatic int memwb_payload_w(input int data_w, input int addr_w);
        return 2 * data_w + addr_w + 2;
    endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// ---------------------------------------------------------------------------
// pipe_skid_reg
// Generic two-entry valid/ready pipeline register on a flat payload vector.
// Entry M drives the outputs; entry S catches the beat that arrives while M
// is stalled, so in_ready is a pure register output (no out_ready path).
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   flush               synchronous flush, empties both entries and drops
//                       any beat accepted in the same cycle
//   in_valid/in_ready   upstream handshake, in_data payload
//   out_valid/out_ready downstream handshake, out_data payload (entry M)
// ---------------------------------------------------------------------------
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int PAYLOAD_W = MEMWB_PAYLOAD_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data
);

    logic                 m_valid_q, m_valid_d;
    logic                 s_valid_q, s_valid_d;
    logic [PAYLOAD_W-1:0] m_data_q,  m_data_d;
    logic [PAYLOAD_W-1:0] s_data_q,  s_data_d;

    logic accept;
    logic consume;

    // Ready only depends on the registered skid flag; rst forces it low so
    // nothing is accepted while the stage is held in reset.
    assign in_ready  = ~s_valid_q & ~rst;
    assign out_valid = m_valid_q;
    assign out_data  = m_data_q;

    assign accept  = in_valid & in_ready;
    assign consume = m_valid_q & out_ready;

    always_comb begin
        m_valid_d = m_valid_q;
        s_valid_d = s_valid_q;
        m_data_d  = m_data_q;
        s_data_d  = s_data_q;

        if (flush) begin
            // Payloads are left alone; only the valid flags matter.
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (consume && s_valid_q) begin
            // in_ready is low whenever S is full, so no accept can coincide.
            m_valid_d = 1'b1;
            m_data_d  = s_data_q;
            s_valid_d = 1'b0;
        end else if (consume) begin
            m_valid_d = accept;
            if (accept) begin
                m_data_d = in_data;
            end
        end else if (!m_valid_q && accept) begin
            m_valid_d = 1'b1;
            m_data_d  = in_data;
        end else if (m_valid_q && accept) begin
            // M stalled: park the new beat in S; in_ready drops next cycle.
            s_valid_d = 1'b1;
            s_data_d  = in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
            m_data_q  <= '0;
            s_data_q  <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            s_valid_q <= s_valid_d;
            m_data_q  <= m_data_d;
            s_data_q  <= s_data_d;
        end
    end

endmodule

// File: rtl/mem_wb_stage_hs.sv
// ---------------------------------------------------------------------------
// mem_wb_stage_hs
// MEM/WB pipeline register with valid/ready handshake, two-entry skid
// buffer and flush, between the data-memory stage and the register-file
// write port.
// Ports:
//   clk, rst, flush                 clock, async active-high reset, flush
//   in_valid / in_ready             upstream handshake
//   in_mem_data, in_alu_result      memory read data, ALU result
//   in_rd, in_reg_write,
//   in_mem_to_reg                   destination and write-back controls
//   out_valid / out_ready           downstream handshake
//   out_mem_data, out_alu_result,
//   out_rd, out_mem_to_reg          held beat fields
//   out_reg_write                   write enable, gated by out_valid and
//                                   (optionally) by out_rd != 0
//   out_wb_data                     write-back data selected by mem_to_reg
// ---------------------------------------------------------------------------
module mem_wb_stage_hs
    import pipe_pkg::*;
#(
    parameter int DATA_W         = MEMWB_DATA_W,
    parameter int REG_ADDR_W     = pipe_pkg::REG_ADDR_W,
    parameter int ZERO_REG_GUARD = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_mem_data,
    input  logic [DATA_W-1:0]     in_alu_result,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_reg_write,
    input  logic                  in_mem_to_reg,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_mem_data,
    output logic [DATA_W-1:0]     out_alu_result,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_reg_write,
    output logic                  out_mem_to_reg,
    output logic [DATA_W-1:0]     out_wb_data
);

    localparam int PAYLOAD_W = memwb_payload_w(DATA_W, REG_ADDR_W);

    logic [PAYLOAD_W-1:0] in_payload;
    logic [PAYLOAD_W-1:0] held_payload;
    logic                 held_reg_write;
    logic                 rd_ok;

    assign in_payload = {in_mem_data, in_alu_result, in_rd, in_reg_write, in_mem_to_reg};

    pipe_skid_reg #(
        .PAYLOAD_W (PAYLOAD_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_payload),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (held_payload)
    );

    assign {out_mem_data, out_alu_result, out_rd, held_reg_write, out_mem_to_reg} = held_payload;

    // Register x0 is hard-wired; optionally stop writes to it at the source.
    generate
        if (ZERO_REG_GUARD != 0) begin : g_zero_guard
            assign rd_ok = |out_rd;
        end else begin : g_no_guard
            assign rd_ok = 1'b1;
        end
    endgenerate

    // Gating by out_valid keeps bubbles and flushed beats off the write port.
    assign out_reg_write = out_valid & held_reg_write & rd_ok;
    assign out_wb_data   = out_mem_to_reg ? out_mem_data : out_alu_result;

endmodule

// File: tb/tb_mem_wb_stage_hs.sv
// ---------------------------------------------------------------------------
// tb_mem_wb_stage_hs
// Directed and random stimulus for mem_wb_stage_hs. The driver pushes the
// expected beat into a scoreboard queue when the beat is accepted; a
// separate monitor pops and compares whenever a beat is consumed.
// ---------------------------------------------------------------------------
module tb_mem_wb_stage_hs;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_mem_data;
    logic [DW-1:0] in_alu_result;
    logic [AW-1:0] in_rd;
    logic          in_reg_write;
    logic          in_mem_to_reg;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_mem_data;
    logic [DW-1:0] out_alu_result;
    logic [AW-1:0] out_rd;
    logic          out_reg_write;
    logic          out_mem_to_reg;
    logic [DW-1:0] out_wb_data;

    typedef struct {
        logic [DW-1:0] mem;
        logic [DW-1:0] alu;
        logic [AW-1:0] rd;
        logic          rw;
        logic          m2r;
        logic [DW-1:0] wb;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mem_wb_stage_hs #(
        .DATA_W         (DW),
        .REG_ADDR_W     (AW),
        .ZERO_REG_GUARD (1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_mem_data    (in_mem_data),
        .in_alu_result  (in_alu_result),
        .in_rd          (in_rd),
        .in_reg_write   (in_reg_write),
        .in_mem_to_reg  (in_mem_to_reg),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_mem_data   (out_mem_data),
        .out_alu_result (out_alu_result),
        .out_rd         (out_rd),
        .out_reg_write  (out_reg_write),
        .out_mem_to_reg (out_mem_to_reg),
        .out_wb_data    (out_wb_data)
    );

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus. Called just after a rising edge; returns just
    // after the next rising edge. Accepted beats go into the scoreboard.
    task automatic drive(input logic iv, input logic [DW-1:0] mem, input logic [DW-1:0] alu,
                         input logic [AW-1:0] rd, input logic rw, input logic m2r,
                         input logic fl, input logic ordy);
        exp_t e;
        in_valid      = iv;
        in_mem_data   = mem;
        in_alu_result = alu;
        in_rd         = rd;
        in_reg_write  = rw;
        in_mem_to_reg = m2r;
        flush         = fl;
        out_ready     = ordy;
        @(negedge clk);
        if (iv && in_ready && !fl && !rst) begin
            e.mem = mem;
            e.alu = alu;
            e.rd  = rd;
            e.rw  = rw && (rd != '0);
            e.m2r = m2r;
            e.wb  = m2r ? mem : alu;
            sb.push_back(e);
            $display("accept alu=0x%0h mem=0x%0h rd=%0d rw=%0b m2r=%0b", alu, mem, rd, rw, m2r);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ordy);
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, ordy);
    endtask

    // Monitor: runs 1 time unit after the push point of each falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                sb.delete();
            end else begin
                if (!out_valid) begin
                    chk("bubble_reg_write", {31'b0, out_reg_write}, 32'd0);
                end else if (out_ready) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_beat: got alu=0x%0h expected no beat at %0t",
                                 out_alu_result, $time);
                    end else begin
                        e = sb.pop_front();
                        $display("consume alu=0x%0h mem=0x%0h rd=%0d rw=%0b wb=0x%0h",
                                 out_alu_result, out_mem_data, out_rd, out_reg_write, out_wb_data);
                        chk("out_alu", out_alu_result, e.alu);
                        chk("out_mem", out_mem_data, e.mem);
                        chk("out_rd", {27'b0, out_rd}, {27'b0, e.rd});
                        chk("out_reg_write", {31'b0, out_reg_write}, {31'b0, e.rw});
                        chk("out_mem_to_reg", {31'b0, out_mem_to_reg}, {31'b0, e.m2r});
                        chk("out_wb_data", out_wb_data, e.wb);
                    end
                end
                if (flush) begin
                    sb.delete();
                end
            end
        end
    end

    initial begin
        // ---- reset with a beat presented ----
        rst           = 1'b1;
        flush         = 1'b0;
        in_valid      = 1'b1;
        in_mem_data   = 32'hDEAD_BEEF;
        in_alu_result = 32'hCAFE_F00D;
        in_rd         = 5'd7;
        in_reg_write  = 1'b1;
        in_mem_to_reg = 1'b1;
        out_ready     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_out_alu", out_alu_result, 32'd0);
        chk("rst_out_mem", out_mem_data, 32'd0);
        chk("rst_out_wb", out_wb_data, 32'd0);
        chk("rst_out_reg_write", {31'b0, out_reg_write}, 32'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rel_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rel_out_valid", {31'b0, out_valid}, 32'd0);

        // ---- streaming: 8 back-to-back beats, no gaps ----
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, 32'h100 + k, k, AW'(k), 1'b1, 1'b0, 1'b0, 1'b1);
            chk("stream_valid", {31'b0, out_valid}, 32'd1);
            chk("stream_alu", out_alu_result, k);
            chk("stream_in_ready", {31'b0, in_ready}, 32'd1);
        end
        idle(1'b1);
        chk("stream_empty", {31'b0, out_valid}, 32'd0);

        // ---- stall: A held, B skidded, then drained in order ----
        drive(1'b1, 32'h0, 32'hA, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h0, 32'hB, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
        chk("stall_valid", {31'b0, out_valid}, 32'd1);
        chk("stall_alu_A", out_alu_result, 32'hA);
        idle(1'b1);
        chk("drain_alu_B", out_alu_result, 32'hB);
        chk("drain_in_ready", {31'b0, in_ready}, 32'd1);
        idle(1'b1);
        chk("drain_empty", {31'b0, out_valid}, 32'd0);

        // ---- flush with M and S full ----
        drive(1'b1, 32'h0, 32'hA1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h0, 32'hB1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h0, 32'hC1, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("flush_full_valid", {31'b0, out_valid}, 32'd0);
        chk("flush_full_in_ready", {31'b0, in_ready}, 32'd1);
        idle(1'b1);
        idle(1'b1);

        // ---- flush drops a beat accepted in the same cycle ----
        drive(1'b1, 32'h0, 32'hD1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h0, 32'hE1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("flush_accept_valid", {31'b0, out_valid}, 32'd0);
        idle(1'b1);

        // ---- flush together with consume ----
        drive(1'b1, 32'h0, 32'hF1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("flush_consume_valid", {31'b0, out_valid}, 32'd0);

        // ---- write-back select and zero-register guard ----
        drive(1'b1, 32'h1234, 32'h5678, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("wb_mem", out_wb_data, 32'h1234);
        drive(1'b1, 32'h1234, 32'h5678, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("wb_alu", out_wb_data, 32'h5678);
        drive(1'b1, 32'h1, 32'h2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("rd0_reg_write", {31'b0, out_reg_write}, 32'd0);
        drive(1'b1, 32'h1, 32'h2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("rd3_reg_write", {31'b0, out_reg_write}, 32'd1);
        idle(1'b1);

        // ---- asynchronous reset mid-stream ----
        drive(1'b1, 32'h0, 32'h77, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("midrst_out_alu", out_alu_result, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("midrst_rel_in_ready", {31'b0, in_ready}, 32'd1);
        chk("midrst_rel_valid", {31'b0, out_valid}, 32'd0);

        // ---- random stall / flush against the scoreboard ----
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom(), $urandom(), AW'($urandom_range(0, 31)),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);
        end
        repeat (4) idle(1'b1);
        chk("final_scoreboard_empty", sb.size(), 32'd0);
        chk("final_out_valid", {31'b0, out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
